hazard_scoreboard_unit: RTL and testbench
=========================================

HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 SHALL have parameter NUM_MC, default 2, number of multicycle units (mult, div, ...), range 1-8.
REQ-002 SHALL have parameter CNT_W, default 32, stall counter width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports, in order:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- halt  in  1  halt decoded in execute
- dread, dwrite  in  1  memory-stage request
- ihit, dhit  in  1  cache hits
- branch_flush  in  1  mispredict from branch unit
- f2dif_rs1, f2dif_rs2  in  REG_W  decode sources
- f2dif_csr  in  1  CSR op in decode
- csr_busy  in  1  CSR op in ex/mem/wb
- d2eif_dread  in  1  load in execute
- d2eif_rd  in  REG_W  execute destination
- mc_issue  in  NUM_MC  one-hot issue of execute op to unit u
- mc_done  in  NUM_MC  unit u wrote its result this cycle
- f2dif_en, d2eif_en, e2mif_en, m2wif_en  out  1  stage enables
- f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush  out  1  stage flushes
- sb_busy  out  2**REG_W  per-register pending-write mask
- unit_busy  out  NUM_MC  per-unit occupancy
- halted  out  1  HALTED state
- stall_cycles  out  CNT_W  stall counter

Function
REQ-005 SHALL keep busy bit and owner index per register; x0 never busy.
REQ-006 SHALL, on mc_issue[u] with e2mif_en=1, set busy[d2eif_rd], owner=u, unit_busy[u], all visible next cycle.
REQ-007 SHALL, on mc_done[u], clear unit_busy[u] and busy[r] for every r with owner u.
REQ-008 SHALL, on same-cycle done and issue of the same register or unit, let issue win.
REQ-009 SHALL compute stalls combinationally, priority high to low: mem wait ((dread|dwrite)&~dhit), structural (mc_issue[u]&unit_busy[u]&~mc_done[u]), RAW (busy[rs1]|busy[rs2], nonzero rs), load-use (d2eif_dread, d2eif_rd!=0, matches rs1/rs2), CSR (f2dif_csr&csr_busy), fetch miss (~ihit).
REQ-010 SHALL on mem wait drive all enables 0, no flushes.
REQ-011 SHALL on structural stall hold fetch/decode/execute, e2mif_flush=1, m2wif_en=1.
REQ-012 SHALL on RAW/load-use/CSR hold fetch/decode, d2eif_flush=1, later stages enabled.
REQ-013 SHALL on fetch miss alone f2dif_flush=1, later stages enabled.
REQ-014 SHALL on branch_flush without mem wait assert f2dif_flush and d2eif_flush, overriding RAW/load-use/CSR/fetch-miss holds.
REQ-015 SHALL implement states RUN, DRAIN, HALTED: RUN->DRAIN on halt with e2mif_en=1; DRAIN holds fetch/decode, flushes d2eif, lets later stages run; DRAIN->HALTED when sb_busy and unit_busy are zero; HALTED drives all enables 0, halted=1; exit only by reset.
REQ-016 SHALL keep scoreboard updates from mc_done active in DRAIN and HALTED.

Reset
REQ-017 SHALL on rst clear scoreboard, owners, unit_busy, stall_cycles, state=RUN; reset mid-operation discards pending writes.
REQ-018 SHALL hold all enables 1, flushes 0 during rst.

Configuration
REQ-019 SHALL, with HAZARD_PERF_EN defined, increment stall_cycles each RUN cycle where f2dif_en=0, saturating at all-ones; without it stall_cycles is constant 0 and no counter exists.

Structure
REQ-020 SHALL place REG_W, NUM_REGS and enum hazard_state_t {RUN, DRAIN, HALTED} in common_types_pkg.
REQ-021 SHALL implement busy/owner storage in sub-module hazard_scoreboard_regs.

Verification
REQ-022 Issue MUL rd=5 on unit 0, decode rs1=5 -> d2eif_flush=1, f2dif_en=0 until cycle after mc_done[0]; sb_busy[5] then 0.
REQ-023 Load rd=3 in execute, decode rs2=3 -> exactly one bubble; rd=0 -> no stall.
REQ-024 Second issue to busy unit 1, mc_done[1] same cycle -> no stall, unit_busy[1] stays 1.
REQ-025 dread&~dhit with branch_flush -> all enables 0, no flushes; flushes appear the cycle dhit rises.
REQ-026 halt with DIV pending -> DRAIN until mc_done, then halted=1 next cycle, enables 0; rst returns RUN, sb_busy=0.
REQ-027 HAZARD_PERF_EN, CNT_W=4, 20 stall cycles -> stall_cycles=15; without macro stays 0.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared register-file geometry and hazard controller state encoding.
package common_types_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 2 ** REG_W;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_scoreboard_regs.sv
// Per-register pending-write busy bits with owning multicycle unit, plus per-unit occupancy.
module hazard_scoreboard_regs
    import common_types_pkg::*;
#(
    parameter int NUM_MC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_en_i,
    input  logic [NUM_MC-1:0]   mc_issue_i,
    input  logic [NUM_MC-1:0]   mc_done_i,
    input  logic [REG_W-1:0]    issue_rd_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [NUM_MC-1:0]   unit_busy_o,
    output logic                idle_next_o
);

    localparam int OWN_W = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [OWN_W-1:0]    owner_q [NUM_REGS];
    logic [OWN_W-1:0]    owner_d [NUM_REGS];
    logic [NUM_MC-1:0]   unit_busy_q, unit_busy_d;
    logic [OWN_W-1:0]    issue_idx;
    logic                issue_any;

    // Completion clears first, then a same-cycle issue re-claims, so issue wins.
    always_comb begin
        issue_idx = '0;
        for (int u = 0; u < NUM_MC; u++) begin
            if (mc_issue_i[u]) begin
                issue_idx = u[OWN_W-1:0];
            end
        end
        issue_any   = issue_en_i & (|mc_issue_i);
        unit_busy_d = (unit_busy_q & ~mc_done_i) | (issue_en_i ? mc_issue_i : '0);
        busy_d      = busy_q;
        owner_d     = owner_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int u = 0; u < NUM_MC; u++) begin
                if (owner_q[r] == u[OWN_W-1:0] && mc_done_i[u]) begin
                    busy_d[r] = 1'b0;
                end
            end
            if (issue_any && issue_rd_i == r[REG_W-1:0]) begin
                busy_d[r]  = 1'b1;
                owner_d[r] = issue_idx;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            unit_busy_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                owner_q[r] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            unit_busy_q <= unit_busy_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                owner_q[r] <= owner_d[r];
            end
        end
    end

    assign busy_o      = busy_q;
    assign unit_busy_o = unit_busy_q;
    assign idle_next_o = (busy_d == '0) && (unit_busy_d == '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller: stall/flush priority, multicycle scoreboard, RUN/DRAIN/HALTED.
// Optional stall counter enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard_unit
    import common_types_pkg::*;
#(
    parameter int NUM_MC = 2,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt,
    input  logic                dread,
    input  logic                dwrite,
    input  logic                ihit,
    input  logic                dhit,
    input  logic                branch_flush,
    input  logic [REG_W-1:0]    f2dif_rs1,
    input  logic [REG_W-1:0]    f2dif_rs2,
    input  logic                f2dif_csr,
    input  logic                csr_busy,
    input  logic                d2eif_dread,
    input  logic [REG_W-1:0]    d2eif_rd,
    input  logic [NUM_MC-1:0]   mc_issue,
    input  logic [NUM_MC-1:0]   mc_done,
    output logic                f2dif_en,
    output logic                d2eif_en,
    output logic                e2mif_en,
    output logic                m2wif_en,
    output logic                f2dif_flush,
    output logic                d2eif_flush,
    output logic                e2mif_flush,
    output logic                m2wif_flush,
    output logic [NUM_REGS-1:0] sb_busy,
    output logic [NUM_MC-1:0]   unit_busy,
    output logic                halted,
    output logic [CNT_W-1:0]    stall_cycles
);

    hazard_state_t state_q;
    logic          halted_q;
    logic          idle_next;
    logic          mem_wait, struct_haz, raw_haz, load_use, csr_haz, fetch_miss;
    logic [3:0]    en_v, fl_v;

    hazard_scoreboard_regs #(.NUM_MC(NUM_MC)) u_regs (
        .clk         (clk),
        .rst         (rst),
        .issue_en_i  (e2mif_en),
        .mc_issue_i  (mc_issue),
        .mc_done_i   (mc_done),
        .issue_rd_i  (d2eif_rd),
        .busy_o      (sb_busy),
        .unit_busy_o (unit_busy),
        .idle_next_o (idle_next)
    );

    assign mem_wait   = (dread | dwrite) & ~dhit;
    assign struct_haz = |(mc_issue & unit_busy & ~mc_done);
    assign raw_haz    = ((f2dif_rs1 != '0) && sb_busy[f2dif_rs1]) ||
                        ((f2dif_rs2 != '0) && sb_busy[f2dif_rs2]);
    assign load_use   = d2eif_dread && (d2eif_rd != '0) &&
                        ((d2eif_rd == f2dif_rs1) || (d2eif_rd == f2dif_rs2));
    assign csr_haz    = f2dif_csr & csr_busy;
    assign fetch_miss = ~ihit;

    // Vectors are {f2dif, d2eif, e2mif, m2wif}.
    always_comb begin
        en_v = 4'b1111;
        fl_v = 4'b0000;
        if (!rst) begin
            case (state_q)
                HALTED: en_v = 4'b0000;
                DRAIN: begin
                    if (mem_wait) begin
                        en_v = 4'b0000;
                    end else begin
                        en_v = 4'b0011;
                        fl_v = 4'b0100;
                    end
                end
                default: begin
                    if (mem_wait) begin
                        en_v = 4'b0000;
                    end else if (struct_haz) begin
                        en_v = 4'b0001;
                        fl_v = 4'b0010;
                    end else if (branch_flush) begin
                        fl_v = 4'b1100;
                    end else if (raw_haz || load_use || csr_haz) begin
                        en_v = 4'b0011;
                        fl_v = 4'b0100;
                    end else if (fetch_miss) begin
                        fl_v = 4'b1000;
                    end
                end
            endcase
        end
    end

    assign {f2dif_en, d2eif_en, e2mif_en, m2wif_en}             = en_v;
    assign {f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush} = fl_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt && e2mif_en) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (idle_next) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign halted = halted_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_q == RUN && !f2dif_en && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: driver pushes expected per-cycle outputs, monitor checks at negedge.
module tb_hazard_scoreboard_unit;
  import common_types_pkg::*;

`ifdef HAZARD_PERF_EN
  localparam int TB_CNT_W = 4;
  localparam bit PERF = 1'b1;
`else
  localparam int TB_CNT_W = 32;
  localparam bit PERF = 1'b0;
`endif

  // Handshake: driver sets inputs 1 time unit after posedge and pushes one
  // expectation; the monitor pops exactly one entry at the following negedge.
  logic clk = 1'b0;
  logic rst, halt, dread, dwrite, ihit, dhit, branch_flush;
  logic [REG_W-1:0] f2dif_rs1, f2dif_rs2, d2eif_rd;
  logic f2dif_csr, csr_busy, d2eif_dread;
  logic [1:0] mc_issue, mc_done;
  logic f2dif_en, d2eif_en, e2mif_en, m2wif_en;
  logic f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush;
  logic [NUM_REGS-1:0] sb_busy;
  logic [1:0] unit_busy;
  logic halted;
  logic [TB_CNT_W-1:0] stall_cycles;

  typedef struct packed {
    logic [3:0]          en;
    logic [3:0]          fl;
    logic [31:0]         sb;
    logic [1:0]          ub;
    logic                hl;
    logic [TB_CNT_W-1:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_nm;
  logic [TB_CNT_W-1:0] sc_model = '0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.NUM_MC(2), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .halt(halt), .dread(dread), .dwrite(dwrite),
    .ihit(ihit), .dhit(dhit), .branch_flush(branch_flush),
    .f2dif_rs1(f2dif_rs1), .f2dif_rs2(f2dif_rs2), .f2dif_csr(f2dif_csr),
    .csr_busy(csr_busy), .d2eif_dread(d2eif_dread), .d2eif_rd(d2eif_rd),
    .mc_issue(mc_issue), .mc_done(mc_done),
    .f2dif_en(f2dif_en), .d2eif_en(d2eif_en), .e2mif_en(e2mif_en), .m2wif_en(m2wif_en),
    .f2dif_flush(f2dif_flush), .d2eif_flush(d2eif_flush),
    .e2mif_flush(e2mif_flush), .m2wif_flush(m2wif_flush),
    .sb_busy(sb_busy), .unit_busy(unit_busy), .halted(halted),
    .stall_cycles(stall_cycles)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      chk(mon_nm, "en", 32'({f2dif_en, d2eif_en, e2mif_en, m2wif_en}), 32'(mon_e.en));
      chk(mon_nm, "flush", 32'({f2dif_flush, d2eif_flush, e2mif_flush, m2wif_flush}), 32'(mon_e.fl));
      chk(mon_nm, "sb_busy", sb_busy, mon_e.sb);
      chk(mon_nm, "unit_busy", 32'(unit_busy), 32'(mon_e.ub));
      chk(mon_nm, "halted", 32'(halted), 32'(mon_e.hl));
      chk(mon_nm, "stall_cycles", 32'(stall_cycles), 32'(mon_e.sc));
    end
  end

  task automatic idle();
    halt = 0; dread = 0; dwrite = 0; ihit = 1; dhit = 1; branch_flush = 0;
    f2dif_rs1 = '0; f2dif_rs2 = '0; f2dif_csr = 0; csr_busy = 0;
    d2eif_dread = 0; d2eif_rd = '0; mc_issue = '0; mc_done = '0;
  endtask

  // in_run: DUT is in RUN this cycle, so a fetch hold counts as a stall cycle.
  task automatic step(input string nm, input logic [3:0] en, input logic [3:0] fl,
                      input logic [31:0] sb, input logic [1:0] ub, input logic hl,
                      input logic in_run);
    exp_t e;
    e.en = en; e.fl = fl; e.sb = sb; e.ub = ub; e.hl = hl; e.sc = sc_model;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (rst) sc_model = '0;
    else if (PERF && in_run && !en[3] && sc_model != '1) sc_model = sc_model + 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    dread = 1; dhit = 0;
    step("rst_forces_en", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 0);
    rst = 0; idle();

    mc_issue = 2'b01; d2eif_rd = 5;
    step("mul_issue", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);
    idle(); f2dif_rs1 = 5;
    step("raw_stall", 4'b0011, 4'b0100, 32'h20, 2'b01, 0, 1);
    mc_done = 2'b01;
    step("raw_done_cycle", 4'b0011, 4'b0100, 32'h20, 2'b01, 0, 1);
    mc_done = 2'b00;
    step("raw_released", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);

    idle(); d2eif_dread = 1; d2eif_rd = 3; f2dif_rs2 = 3;
    step("load_use", 4'b0011, 4'b0100, 32'h0, 2'b00, 0, 1);
    d2eif_dread = 0; d2eif_rd = 0;
    step("load_bubble_gone", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);
    d2eif_dread = 1; d2eif_rd = 0; f2dif_rs2 = 0;
    step("load_rd_x0", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);

    idle(); mc_issue = 2'b10; d2eif_rd = 7;
    step("div_issue", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);
    mc_issue = 2'b10; d2eif_rd = 8; mc_done = 2'b10;
    step("issue_with_done", 4'b1111, 4'b0000, 32'h80, 2'b10, 0, 1);
    idle(); mc_issue = 2'b10; d2eif_rd = 9;
    step("struct_stall", 4'b0001, 4'b0010, 32'h100, 2'b10, 0, 1);
    idle(); mc_done = 2'b10;
    step("struct_done", 4'b1111, 4'b0000, 32'h100, 2'b10, 0, 1);
    idle();
    step("unit_clear", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);
    mc_issue = 2'b01; d2eif_rd = 0;
    step("issue_rd_x0", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);
    idle();
    step("x0_never_busy", 4'b1111, 4'b0000, 32'h0, 2'b01, 0, 1);

    mc_issue = 2'b10; d2eif_rd = 4; mc_done = 2'b01;
    step("reg4_issue_u1", 4'b1111, 4'b0000, 32'h0, 2'b01, 0, 1);
    mc_issue = 2'b01; d2eif_rd = 4; mc_done = 2'b10;
    step("reg4_done_and_issue", 4'b1111, 4'b0000, 32'h10, 2'b10, 0, 1);
    idle();
    step("reg4_issue_won", 4'b1111, 4'b0000, 32'h10, 2'b01, 0, 1);
    mc_done = 2'b01;
    step("reg4_final_done", 4'b1111, 4'b0000, 32'h10, 2'b01, 0, 1);
    idle();
    step("reg4_clear", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);

    dread = 1; dhit = 0; branch_flush = 1;
    step("mem_wait_branch", 4'b0000, 4'b0000, 32'h0, 2'b00, 0, 1);
    dhit = 1;
    step("branch_after_dhit", 4'b1111, 4'b1100, 32'h0, 2'b00, 0, 1);
    idle(); ihit = 0;
    step("fetch_miss", 4'b1111, 4'b1000, 32'h0, 2'b00, 0, 1);
    f2dif_csr = 1; csr_busy = 1; branch_flush = 1;
    step("branch_over_csr", 4'b1111, 4'b1100, 32'h0, 2'b00, 0, 1);

    idle(); mc_issue = 2'b10; d2eif_rd = 6;
    step("div_pending", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);
    idle(); halt = 1;
    step("halt_in_ex", 4'b1111, 4'b0000, 32'h40, 2'b10, 0, 1);
    idle();
    step("drain", 4'b0011, 4'b0100, 32'h40, 2'b10, 0, 0);
    mc_done = 2'b10;
    step("drain_done", 4'b0011, 4'b0100, 32'h40, 2'b10, 0, 0);
    idle();
    step("halted", 4'b0000, 4'b0000, 32'h0, 2'b00, 1, 0);
    f2dif_csr = 1; csr_busy = 1;
    step("halted_hold", 4'b0000, 4'b0000, 32'h0, 2'b00, 1, 0);
    idle(); rst = 1;
    step("rst_from_halted", 4'b1111, 4'b0000, 32'h0, 2'b00, 1, 0);
    rst = 0;
    step("run_after_rst", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);

    mc_issue = 2'b01; d2eif_rd = 2;
    step("issue_before_rst", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);
    idle(); rst = 1;
    step("rst_pending", 4'b1111, 4'b0000, 32'h4, 2'b01, 0, 0);
    rst = 0;
    step("rst_discarded", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);

    for (int i = 0; i < 20; i++) begin
      f2dif_csr = 1; csr_busy = 1;
      step("csr_stall", 4'b0011, 4'b0100, 32'h0, 2'b00, 0, 1);
    end
    idle();
    step("stall_count", 4'b1111, 4'b0000, 32'h0, 2'b00, 0, 1);

    repeat (2) @(posedge clk);
    chk("queue_drained", "entries", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
